// File: rtl/process_scheduler_pkg.sv
// Shared types for the round-robin process scheduler.
//   state_e  : context-switch sequencer states
//   slot_e   : per-process slot status
//   reason_e : why the running process is leaving the core
package sched_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned NPROC_DEFAULT = 4;
  localparam logic [WORD_W-1:0] QUANTUM_DEFAULT = 32'd100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_REQ,
    ST_SAVE,
    ST_SELECT,
    ST_LOAD
  } state_e;

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_READY,
    SLOT_RUNNING,
    SLOT_DONE
  } slot_e;

  typedef enum logic {
    RSN_PREEMPT,
    RSN_HALT
  } reason_e;

endpackage

// File: rtl/process_scheduler_if.sv
// Scheduler <-> core/timer signal bundle.
//   master : scheduler side (drives ctx_req, load_*, set_quantum, quantum_val, cur_pid, idle)
//   slave  : core/timer side (drives quantum_expired, proc_halt, proc_create, create_*, cur_pc, ctx_ack)
interface process_scheduler_if
  import sched_pkg::*;
#(
  parameter int unsigned PID_W = $clog2(NPROC_DEFAULT)
);

  logic              quantum_expired;
  logic              proc_halt;
  logic              proc_create;
  logic [PID_W-1:0]  create_id;
  logic [WORD_W-1:0] create_pc;
  logic [WORD_W-1:0] create_base;
  logic [WORD_W-1:0] cur_pc;
  logic              ctx_ack;
  logic              ctx_req;
  logic              load_valid;
  logic [WORD_W-1:0] load_pc;
  logic [WORD_W-1:0] load_base;
  logic              set_quantum;
  logic [WORD_W-1:0] quantum_val;
  logic [PID_W-1:0]  cur_pid;
  logic              idle;

  modport master (
    input  quantum_expired, proc_halt, proc_create, create_id, create_pc,
           create_base, cur_pc, ctx_ack,
    output ctx_req, load_valid, load_pc, load_base, set_quantum, quantum_val,
           cur_pid, idle
  );

  modport slave (
    output quantum_expired, proc_halt, proc_create, create_id, create_pc,
           create_base, cur_pc, ctx_ack,
    input  ctx_req, load_valid, load_pc, load_base, set_quantum, quantum_val,
           cur_pid, idle
  );

endinterface

// File: rtl/process_scheduler_rr_pick.sv
// Combinational round-robin picker: first set bit of ready at or after start,
// wrapping modulo N (N must be a power of two).
//   ready : request vector
//   start : highest-priority index
//   found : any bit set
//   pid   : chosen index (0 when none found)
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     ready,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] pid
);

  always_comb begin
    found = 1'b0;
    pid   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (!found && ready[IDX_W'(start + IDX_W'(i))]) begin
        found = 1'b1;
        pid   = IDX_W'(start + IDX_W'(i));
      end
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// Round-robin process scheduler: keeps the process table and sequences the
// context switch with the core (request, ack, save PC, pick, load PC/base,
// reload quantum).
//   clk, rst : core clock, asynchronous active-high reset
//   bus      : scheduler side of process_scheduler_if (see interface header)
module process_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned       NPROC   = NPROC_DEFAULT,
  parameter logic [WORD_W-1:0] QUANTUM = QUANTUM_DEFAULT,
  parameter int unsigned       PID_W   = $clog2(NPROC)
) (
  input  logic                clk,
  input  logic                rst,
  process_scheduler_if.master bus
);

  state_e            state, next_state;
  reason_e           reason, next_reason;

  slot_e             status   [NPROC];
  logic [WORD_W-1:0] saved_pc [NPROC];
  logic [WORD_W-1:0] base     [NPROC];

  logic [PID_W-1:0]  cur_pid;
  logic [PID_W-1:0]  rr_start;
  logic [PID_W-1:0]  pick_pid;
  logic [NPROC-1:0]  ready;
  logic              found;
  logic              switching;
  logic              create_ok;

  logic              ctx_req;
  logic              load_valid;
  logic              set_quantum;
  logic              idle;
  logic [WORD_W-1:0] load_pc;
  logic [WORD_W-1:0] load_base;

  // Ready vector for the picker
  always_comb begin
    for (int i = 0; i < int'(NPROC); i++) begin
      ready[i] = (status[i] == SLOT_READY);
    end
  end

  // Search starts just after the current process so it is checked last
  assign rr_start = cur_pid + PID_W'(1);

  rr_pick #(
    .N     (NPROC),
    .IDX_W (PID_W)
  ) u_rr_pick (
    .ready (ready),
    .start (rr_start),
    .found (found),
    .pid   (pick_pid)
  );

  assign switching = (state == ST_REQ) || (state == ST_SAVE) ||
                     (state == ST_SELECT) || (state == ST_LOAD);

  // A create may not clobber the running/switching process, nor the slot
  // being dispatched in this very SELECT cycle.
  assign create_ok = bus.proc_create
                   && !((bus.create_id == cur_pid) &&
                        ((status[cur_pid] == SLOT_RUNNING) || switching))
                   && !((state == ST_SELECT) && found && (bus.create_id == pick_pid));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      reason <= RSN_PREEMPT;
    end else begin
      state  <= next_state;
      reason <= next_reason;
    end
  end

  // Next-state logic
  always_comb begin
    next_state  = state;
    next_reason = reason;
    case (state)
      ST_IDLE: begin
        if (|ready) begin
          next_state  = ST_SELECT;
          next_reason = RSN_PREEMPT;
        end
      end
      ST_RUN: begin
        // Halt takes priority over a coincident quantum expiry
        if (bus.proc_halt) begin
          next_state  = ST_REQ;
          next_reason = RSN_HALT;
        end else if (bus.quantum_expired) begin
          next_state  = ST_REQ;
          next_reason = RSN_PREEMPT;
        end
      end
      ST_REQ: begin
        if (bus.ctx_ack) begin
          next_state = (reason == RSN_PREEMPT) ? ST_SAVE : ST_SELECT;
        end
      end
      ST_SAVE:   next_state = ST_SELECT;
      ST_SELECT: next_state = found ? ST_LOAD : ST_IDLE;
      ST_LOAD:   next_state = ST_RUN;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Process table
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NPROC); i++) begin
        status[i]   <= SLOT_FREE;
        saved_pc[i] <= '0;
        base[i]     <= '0;
      end
    end else begin
      if (create_ok) begin
        status[bus.create_id]   <= SLOT_READY;
        saved_pc[bus.create_id] <= bus.create_pc;
        base[bus.create_id]     <= bus.create_base;
      end
      case (state)
        ST_SAVE: begin
          saved_pc[cur_pid] <= bus.cur_pc;
          status[cur_pid]   <= SLOT_READY;
        end
        ST_SELECT: begin
          if (reason == RSN_HALT) status[cur_pid] <= SLOT_DONE;
          if (found)              status[pick_pid] <= SLOT_RUNNING;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs, aligned with the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctx_req     <= 1'b0;
      load_valid  <= 1'b0;
      set_quantum <= 1'b0;
      idle        <= 1'b1;
      load_pc     <= '0;
      load_base   <= '0;
      cur_pid     <= '0;
    end else begin
      ctx_req     <= (next_state == ST_REQ);
      load_valid  <= (next_state == ST_LOAD);
      set_quantum <= (next_state == ST_LOAD);
      idle        <= (next_state == ST_IDLE);
      if ((state == ST_SELECT) && found) begin
        load_pc   <= saved_pc[pick_pid];
        load_base <= base[pick_pid];
        cur_pid   <= pick_pid;
      end
    end
  end

  assign bus.ctx_req     = ctx_req;
  assign bus.load_valid  = load_valid;
  assign bus.set_quantum = set_quantum;
  assign bus.idle        = idle;
  assign bus.load_pc     = load_pc;
  assign bus.load_base   = load_base;
  assign bus.cur_pid     = cur_pid;
  assign bus.quantum_val = QUANTUM;

endmodule
